// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: synchronizes rx, samples each bit at its centre and emits one byte
// with a single-cycle new_data strobe, or a frame_err strobe when the stop bit is low.
module uart_rx_byte #(
  parameter int unsigned CLK_PER_BIT = 50,
  parameter int unsigned CTR_BITS    = $clog2(CLK_PER_BIT)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       new_data,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StStartBit = 3'd1,
    StData     = 3'd2,
    StStopBit  = 3'd3,
    StWaitHigh = 3'd4
  } state_e;

  localparam logic [CTR_BITS-1:0] HalfCtr = CTR_BITS'(CLK_PER_BIT / 2 - 1);
  localparam logic [CTR_BITS-1:0] LastCtr = CTR_BITS'(CLK_PER_BIT - 1);

  state_e              state_q, state_d;
  logic [CTR_BITS-1:0] ctr_q, ctr_d;
  logic [2:0]          bit_ctr_q, bit_ctr_d;
  logic [7:0]          shift_q, shift_d;
  logic [7:0]          data_q, data_d;
  logic                new_data_q, new_data_d;
  logic                frame_err_q, frame_err_d;
  logic                sync1_q, rx_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b1;
      rx_s        <= 1'b1;
      state_q     <= StIdle;
      ctr_q       <= '0;
      bit_ctr_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      new_data_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync1_q     <= rx;
      rx_s        <= sync1_q;
      state_q     <= state_d;
      ctr_q       <= ctr_d;
      bit_ctr_q   <= bit_ctr_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      new_data_q  <= new_data_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ctr_d       = ctr_q;
    bit_ctr_d   = bit_ctr_q;
    shift_d     = shift_q;
    data_d      = data_q;
    new_data_d  = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        ctr_d     = '0;
        bit_ctr_d = '0;
        if (!rx_s) state_d = StStartBit;
      end
      StStartBit: begin
        ctr_d = ctr_q + 1'b1;
        if (ctr_q == HalfCtr) begin
          ctr_d   = '0;
          // Line back high at the start-bit centre means it was only a glitch.
          state_d = rx_s ? StIdle : StData;
        end
      end
      StData: begin
        ctr_d = ctr_q + 1'b1;
        if (ctr_q == LastCtr) begin
          shift_d[bit_ctr_q] = rx_s;
          ctr_d              = '0;
          bit_ctr_d          = bit_ctr_q + 3'd1;
          if (bit_ctr_q == 3'd7) state_d = StStopBit;
        end
      end
      StStopBit: begin
        ctr_d = ctr_q + 1'b1;
        if (ctr_q == LastCtr) begin
          ctr_d = '0;
          if (rx_s) begin
            data_d     = shift_q;
            new_data_d = 1'b1;
            state_d    = StIdle;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StWaitHigh;
          end
        end
      end
      StWaitHigh: begin
        // A held-low break line must not restart reception until it idles high.
        ctr_d = '0;
        if (rx_s) state_d = StIdle;
      end
      default: begin
        state_d   = StIdle;
        ctr_d     = '0;
        bit_ctr_d = '0;
      end
    endcase
  end

  assign data      = data_q;
  assign new_data  = new_data_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 16 clocks per bit: table of clean frames plus
// hand-written glitch, framing-error, back-to-back and mid-frame reset sequences.
module tb_uart_rx_byte;

  localparam int unsigned Cpb = 16;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       new_data;
  logic       frame_err;
  logic       busy;

  uart_rx_byte #(.CLK_PER_BIT(Cpb)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .data     (data),
    .new_data (new_data),
    .frame_err(frame_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;
  int cyc;
  int start_cyc;
  int nd_cnt, fe_cnt, nd_cyc, overlap_cnt, data_glitch_cnt;
  logic [7:0] nd_data, prev_data;
  logic busy_seen;

  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor, sampled on the falling edge away from DUT updates.
  always @(negedge clk) begin
    if (!rst) begin
      if (new_data) begin
        nd_cnt  <= nd_cnt + 1;
        nd_cyc  <= cyc;
        nd_data <= data;
      end
      if (frame_err) fe_cnt <= fe_cnt + 1;
      if (new_data && frame_err) overlap_cnt <= overlap_cnt + 1;
      if (data != prev_data && !new_data) data_glitch_cnt <= data_glitch_cnt + 1;
      if (busy) busy_seen <= 1'b1;
    end
    prev_data <= data;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Call just after a rising edge (#1 past it); leaves time just after a rising edge.
  task automatic bit_time(input logic v);
    rx = v;
    repeat (Cpb) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    start_cyc = cyc;
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(stop);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] val;
    logic [7:0] exp_data;
    int         exp_lat;
  } vec_t;

  vec_t vecs[4];
  int   nd0, fe0, nd_first, fe_hold;
  logic [7:0] data_hold;

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0;
    nd_cnt = 0; fe_cnt = 0; nd_cyc = 0; overlap_cnt = 0; data_glitch_cnt = 0;
    nd_data = 8'h00; prev_data = 8'h00; busy_seen = 1'b0;

    vecs[0] = '{val: 8'h55, exp_data: 8'h55, exp_lat: 155};
    vecs[1] = '{val: 8'h00, exp_data: 8'h00, exp_lat: 155};
    vecs[2] = '{val: 8'hFF, exp_data: 8'hFF, exp_lat: 155};
    vecs[3] = '{val: 8'hC3, exp_data: 8'hC3, exp_lat: 155};

    // Reset
    rst = 1'b1; rx = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset data", data, 0);
    check("reset new_data", new_data, 0);
    check("reset frame_err", frame_err, 0);
    check("reset busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(5);

    // Clean frames
    foreach (vecs[i]) begin
      nd0 = nd_cnt; fe0 = fe_cnt;
      send_frame(vecs[i].val, 1'b1);
      idle(10);
      check($sformatf("vec%0d strobes", i), nd_cnt - nd0, 1);
      check($sformatf("vec%0d frame_err", i), fe_cnt - fe0, 0);
      check($sformatf("vec%0d data", i), nd_data, vecs[i].exp_data);
      check($sformatf("vec%0d held data", i), data, vecs[i].exp_data);
      check_range($sformatf("vec%0d latency", i), nd_cyc - start_cyc,
                  vecs[i].exp_lat - 1, vecs[i].exp_lat + 1);
      check($sformatf("vec%0d busy idle", i), busy, 0);
    end

    // Back-to-back
    nd0 = nd_cnt;
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("b2b first data", nd_data, 8'h3C);
    nd_first = nd_cyc;
    idle(10);
    check("b2b strobes", nd_cnt - nd0, 2);
    check("b2b data", data, 8'h3C);
    // Re-run to capture spacing between the two strobes.
    send_frame(8'hA5, 1'b1);
    nd_first = nd_cyc;
    check("b2b data A5", nd_data, 8'hA5);
    send_frame(8'h3C, 1'b1);
    idle(10);
    check("b2b spacing", nd_cyc - nd_first, 160);
    check("b2b data 3C", nd_data, 8'h3C);

    // Glitch
    nd0 = nd_cnt; fe0 = fe_cnt;
    busy_seen = 1'b0;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle(30);
    check("glitch busy pulse", busy_seen, 1);
    check("glitch busy idle", busy, 0);
    check("glitch strobes", nd_cnt - nd0, 0);
    check("glitch frame_err", fe_cnt - fe0, 0);
    send_frame(8'h81, 1'b1);
    idle(10);
    check("post-glitch data", nd_data, 8'h81);
    check("post-glitch strobes", nd_cnt - nd0, 1);

    // Framing error with held-low line
    nd0 = nd_cnt; fe0 = fe_cnt; data_hold = data;
    send_frame(8'hF0, 1'b0);
    repeat (100) @(posedge clk);
    @(negedge clk);
    check("ferr pulses", fe_cnt - fe0, 1);
    check("ferr strobes", nd_cnt - nd0, 0);
    check("ferr data kept", data, data_hold);
    check("ferr busy held", busy, 1);
    @(posedge clk); #1;
    idle(6);
    check("ferr busy released", busy, 0);
    fe_hold = fe_cnt;
    idle(20);
    check("ferr no repeat", fe_cnt - fe0, 1);
    check("ferr stable", fe_cnt, fe_hold);

    // Reset mid-frame during data bit 4 of 0x33
    nd0 = nd_cnt; fe0 = fe_cnt;
    bit_time(1'b0);
    for (int i = 0; i < 4; i++) bit_time(1'b0 ^ ((8'h33 >> i) & 1));
    rx = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midreset busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(200);
    check("midreset no strobe", nd_cnt - nd0, 0);
    check("midreset no ferr", fe_cnt - fe0, 0);
    send_frame(8'h7E, 1'b1);
    idle(10);
    check("post-reset strobes", nd_cnt - nd0, 1);
    check("post-reset data", data, 8'h7E);

    check("strobe overlap", overlap_cnt, 0);
    check("data changed without strobe", data_glitch_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_byte.md
# uart_rx_byte

Receives a single byte of 8N1 UART serial data on one input line and presents it as a parallel byte with a one-cycle valid strobe. It is the receive-side counterpart of the byte transmitter and sits between the board's serial RX pin and the byte-level logic that consumes commands. Bit timing uses a fixed clocks-per-bit count; for 115,200 baud at 50 MHz that count is 434. Each bit is sampled at its centre.

## Interface
- CLK_PER_BIT, 50, system clocks per serial bit; must be at least 4.
- CTR_BITS, $clog2(CLK_PER_BIT), width of the bit-period counter.
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line, idle high.
- data  output  8  last received byte, LSB received first.
- new_data  output  1  one-cycle pulse; data is valid in the same cycle.
- frame_err  output  1  one-cycle pulse; stop bit sampled low, byte discarded.
- busy  output  1  high whenever state is not IDLE.

## Operation
- rx passes through a 2-flop synchronizer to produce rx_s. Both flops reset to 1. All decisions use rx_s only.
- States are IDLE, START_BIT, DATA, STOP_BIT and WAIT_HIGH. The state register is 3 bits wide.
- IDLE: ctr=0 and bit_ctr=0. When rx_s==0, go to START_BIT.
- START_BIT: ctr increments each cycle. At ctr==CLK_PER_BIT/2-1 (integer division):
  - If rx_s==0, clear ctr and go to DATA. This is the start-bit centre.
  - If rx_s==1, go to IDLE. The low pulse was a glitch; nothing is output.
- DATA: ctr increments each cycle. At ctr==CLK_PER_BIT-1:
  - Shift rx_s into shift register bit bit_ctr, clear ctr, increment bit_ctr.
  - If bit_ctr==7, go to STOP_BIT.
  - bit_ctr is 3 bits and wraps 7->0.
- STOP_BIT: ctr increments each cycle. At ctr==CLK_PER_BIT-1, sample rx_s:
  - If rx_s==1: load data from the shift register, pulse new_data, go to IDLE.
  - If rx_s==0: pulse frame_err, leave data unchanged, go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s==1, then go to IDLE. A held-low line (break) therefore never produces repeated frames.
- Undefined state encodings go to IDLE.
- data changes only in the cycle new_data is high, and holds between strobes.
- No flow control. A consumer that misses a strobe loses that byte. A byte that begins right after a stop bit is received normally.

## Timing
- Reset values:
  - data=0x00, new_data=0, frame_err=0, busy=0.
  - state=IDLE, ctr=0, bit_ctr=0, synchronizer flops=1.
- Reset mid-frame returns to IDLE on the next edge with no strobe. The partial byte is dropped.
- new_data and frame_err are registered. Each is high for exactly one cycle and they are never high together.
- Synchronizer latency is 2 cycles from an rx transition to rx_s.
- Sample points, measured from the rx falling edge of the start bit, fall at approximately:
  - CLK_PER_BIT/2 + 3 cycles for the start check,
  - then every CLK_PER_BIT cycles for the 8 data bits and the stop bit.
- new_data or frame_err asserts 9.5*CLK_PER_BIT + 3 cycles (±1) after the start edge.
- busy rises 3 cycles after the start edge. It falls the cycle after the strobe, or once the line returns high from WAIT_HIGH.
- Tolerance: sampling stays within a bit for cumulative baud mismatch under ±4% over 10 bits.

## Test plan
- Reset: hold rst 3 cycles with rx=1. Required: data=0x00, new_data=0, frame_err=0, busy=0.
- Single byte: CLK_PER_BIT=16, send 0x55. Required: exactly one new_data pulse at start edge +155±1 cycles, data=0x55, no frame_err.
- Back-to-back: send 0xA5 then immediately 0x3C. Required: two new_data pulses 160 cycles apart, with data=0xA5 then 0x3C.
- Glitch: drive rx low for 4 cycles, then high. Required: busy pulses briefly, no new_data or frame_err, returns to IDLE. A following 0x81 frame is received correctly.
- Framing error: send 0xF0 with the stop bit driven 0 and hold rx low 100 further cycles. Required: one frame_err pulse, data keeps its previous value, busy stays high until rx returns high, and there is no second frame_err.
- Reset mid-frame: assert rst during data bit 4 of 0x33, then send 0x7E. Required: no strobe for 0x33, and new_data with data=0x7E.
